uart_tx_drain: RTL

- Downstream consumer of the team's 8-bit, 16-deep FIFO.
- Pops one byte at a time through the FIFO read port (rd_en / dout / empty), then serialises it as an asynchronous UART frame on a single TX line: start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Sits between the FIFO and the board-level serial pin.

---
 rtl/uart_tx_drain.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_drain.sv
// Drains bytes from the upstream FIFO and serialises each one as a UART frame:
// start bit, 8 data bits LSB first, optional parity bit, then 1 or 2 stop bits.
module uart_tx_drain #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_dout,
    output logic        fifo_rd_en,
    output logic        tx,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frames_sent
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic              ODD_INV   = (PARITY_ODD != 0);
    localparam logic              PAR_ON    = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              tx_q, tx_d;
    logic [15:0]       frames_sent_q, frames_sent_d;
    logic              frame_done_c;
    logic              baud_last;

    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d       = state_q;
        baud_d        = '0;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        parity_d      = parity_q;
        tx_d          = tx_q;
        frames_sent_d = frames_sent_q;
        frame_done_c  = 1'b0;

        // Bit-timed states share one baud counter that restarts at every bit boundary.
        if (state_q == S_START || state_q == S_DATA ||
            state_q == S_PARITY || state_q == S_STOP) begin
            baud_d = baud_last ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (en && !fifo_empty) state_d = S_FETCH;
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                shift_d   = fifo_dout;
                parity_d  = (^fifo_dout) ^ ODD_INV;
                bit_cnt_d = '0;
                tx_d      = 1'b0;
                state_d   = S_START;
            end
            S_START: begin
                if (baud_last) begin
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        if (PAR_ON) begin
                            tx_d    = parity_q;
                            state_d = S_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        tx_d = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (baud_last) begin
                    tx_d      = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                // bit_cnt_q counts completed stop bits here
                if (baud_last) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        frame_done_c  = 1'b1;
                        frames_sent_d = frames_sent_q + 16'd1;
                        bit_cnt_d     = '0;
                        state_d       = S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            baud_q        <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            tx_q          <= 1'b1;
            frames_sent_q <= '0;
        end else begin
            state_q       <= state_d;
            baud_q        <= baud_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            tx_q          <= tx_d;
            frames_sent_q <= frames_sent_d;
        end
    end

    assign fifo_rd_en  = (state_q == S_FETCH);
    assign busy        = (state_q != S_IDLE);
    assign tx          = tx_q;
    assign frame_done  = frame_done_c;
    assign frames_sent = frames_sent_q;

endmodule
